// File: rtl/pipe_pkg.sv
// Shared encodings, widths and helpers for the pipeline hazard controller.
package pipe_pkg;

   localparam int unsigned REG_W       = 5;
   localparam int unsigned TW          = 2;
   localparam int unsigned CNT_W       = 4;
   localparam int unsigned MULT_CYCLES = 5;
   localparam int unsigned DIV_CYCLES  = 10;

   typedef enum logic [1:0] {
      ST_RUN = 2'd0,
      ST_MD  = 2'd1,
      ST_EXC = 2'd2
   } state_e;

   // A source operand hazards when an in-flight writer produces it later than it is needed.
   function automatic logic src_hazard(input logic [REG_W-1:0] src,
                                       input logic [TW-1:0]    tuse,
                                       input logic [REG_W-1:0] e_a3,
                                       input logic [TW-1:0]    e_tnew,
                                       input logic [REG_W-1:0] m_a3,
                                       input logic [TW-1:0]    m_tnew);
      return (src != '0) &&
             (((e_a3 == src) && (e_tnew > tuse)) || ((m_a3 == src) && (m_tnew > tuse)));
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode/execute/memory hazard inputs and stall/enable outputs of pipe_ctrl.
interface pipe_ctrl_if;
   import pipe_pkg::*;

   logic [REG_W-1:0] D_rs, D_rt, E_A3, M_A3;
   logic [TW-1:0]    D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
   logic             D_is_md, E_md_start, E_md_op, Req;
   logic             stall, en_PC, en_FD, en_DE, en_EM, md_busy;
   logic [1:0]       state;

   modport master (
      output D_rs, D_rt, E_A3, M_A3, D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew,
             D_is_md, E_md_start, E_md_op, Req,
      input  stall, en_PC, en_FD, en_DE, en_EM, md_busy, state
   );

   modport slave (
      input  D_rs, D_rt, E_A3, M_A3, D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew,
             D_is_md, E_md_start, E_md_op, Req,
      output stall, en_PC, en_FD, en_DE, en_EM, md_busy, state
   );

endinterface

// File: rtl/md_busy_counter.sv
// Mult/div occupancy counter: loads the operation latency, then counts down to idle.
module md_busy_counter
   import pipe_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             op,
   input  logic             tick,
   output logic             busy,
   output logic [CNT_W-1:0] count_nxt_c
);

   logic [CNT_W-1:0] count_d, count_q;

   // A start while still busy is ignored rather than reloading.
   always_comb begin
      count_d = count_q;
      if (load && (count_q == '0)) begin
         count_d = op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (tick && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign busy        = (count_q != '0);
   assign count_nxt_c = count_d;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/enable controller with RUN/MD/EXC sequencing.
// Define PIPE_CTRL_MDU_EN to build the mult/div busy counter, MD state and mult/div hazard.
module pipe_ctrl
   import pipe_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   pipe_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   logic             hz_rs, hz_rt, hz_md, md_busy, md_load;
   logic             stall_c, en_pc_c, en_fd_c;
   logic [CNT_W-1:0] cnt_nxt_c;

   assign hz_rs = src_hazard(bus.D_rs, bus.D_Tuse_rs, bus.E_A3, bus.E_Tnew, bus.M_A3, bus.M_Tnew);
   assign hz_rt = src_hazard(bus.D_rt, bus.D_Tuse_rt, bus.E_A3, bus.E_Tnew, bus.M_A3, bus.M_Tnew);

`ifdef PIPE_CTRL_MDU_EN
   assign md_load = (state_q == ST_RUN) && bus.E_md_start && !bus.Req;

   md_busy_counter u_md_cnt (
      .clk         (clk),
      .reset       (reset),
      .load        (md_load),
      .op          (bus.E_md_op),
      .tick        (state_q != ST_RUN),
      .busy        (md_busy),
      .count_nxt_c (cnt_nxt_c)
   );

   assign hz_md = bus.D_is_md && (md_busy || bus.E_md_start);
`else
   logic unused_md;
   assign unused_md = ^{bus.D_is_md, bus.E_md_start, bus.E_md_op};
   assign md_load   = 1'b0;
   assign md_busy   = 1'b0;
   assign cnt_nxt_c = '0;
   assign hz_md     = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_RUN;
      else        state_q <= state_d;
   end

   // Exceptions win in every state; leaving EXC or MD follows the post-edge count.
   always_comb begin
      state_d = ST_RUN;
      if (bus.Req) begin
         state_d = ST_EXC;
      end else begin
         case (state_q)
            ST_RUN:        state_d = md_load ? ST_MD : ST_RUN;
            ST_MD, ST_EXC: state_d = (cnt_nxt_c != '0) ? ST_MD : ST_RUN;
            default:       state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      stall_c = 1'b0;
      en_pc_c = 1'b1;
      en_fd_c = 1'b1;
      if (reset && (hz_rs || hz_rt || hz_md) && !bus.Req && (state_q != ST_EXC)) begin
         stall_c = 1'b1;
         en_pc_c = 1'b0;
         en_fd_c = 1'b0;
      end
   end

   assign bus.stall   = stall_c;
   assign bus.en_PC   = en_pc_c;
   assign bus.en_FD   = en_fd_c;
   assign bus.en_DE   = 1'b1;
   assign bus.en_EM   = 1'b1;
   assign bus.md_busy = md_busy;
   assign bus.state   = state_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL: D_rs, D_rt  in  5 each  source register numbers of the decode-stage instruction.
REQ-004 SHALL: D_Tuse_rs, D_Tuse_rt  in  2 each  cycles until decode-stage instruction consumes rs/rt.
REQ-005 SHALL: E_A3, M_A3  in  5 each  destination register in E / M stage (0 = none).
REQ-006 SHALL: E_Tnew, M_Tnew  in  2 each  cycles until E / M result is forwardable.
REQ-007 SHALL: D_is_md  in  1  decode-stage instruction uses the mult/div unit (mult, div, mfhi, mflo, mthi, mtlo).
REQ-008 SHALL: E_md_start  in  1  E-stage mult/div starts this cycle; E_md_op  in  1  0 = mult, 1 = div.
REQ-009 SHALL: Req  in  1  exception/interrupt request from CP0.
REQ-010 SHALL: stall  out  1  drives the D_E stall input and inserts a bubble.
REQ-011 SHALL: en_PC, en_FD, en_DE, en_EM  out  1 each  pipeline register enables.
REQ-012 SHALL: md_busy  out  1  mult/div unit occupied; state  out  2  FSM state, for debug.

Function
REQ-013 SHALL: hz_rs = (D_rs!=0) & ((E_A3==D_rs & E_Tnew>D_Tuse_rs) | (M_A3==D_rs & M_Tnew>D_Tuse_rs)); hz_rt is defined identically on D_rt.
REQ-014 SHALL: hz_md = D_is_md & (md_busy | E_md_start).
REQ-015 SHALL: stall = (hz_rs | hz_rt | hz_md) & ~Req & (state!=EXC); combinational, no added latency.
REQ-016 SHALL: stall=1 -> en_PC=0, en_FD=0, en_DE=1, en_EM=1; otherwise all enables are 1.
REQ-017 SHALL: Req=1 forces stall=0 and all enables to 1 in the same cycle (Req has priority over every hazard).
REQ-018 SHALL: FSM states are RUN=0, MD=1, EXC=2; code 3 is unreachable and recovers to RUN on the next edge.
REQ-019 SHALL: RUN->MD on E_md_start & ~Req; loads a 4-bit counter with 5 (mult) or 10 (div).
REQ-020 SHALL: in MD the counter decrements by 1 per cycle; md_busy = (count!=0); MD->RUN on the edge where the count goes 1->0.
REQ-021 SHALL: Req in any state -> EXC for exactly one cycle, then return to MD if count!=0, else RUN.
REQ-022 SHALL: an in-flight mult/div is not cancelled by Req and keeps counting through EXC.
REQ-023 SHALL: E_md_start together with Req in the same cycle is dropped: no counter load.
REQ-024 SHALL: E_md_start while count!=0 is ignored; the counter is not reloaded.

Reset
REQ-025 SHALL: reset low immediately sets state=RUN, count=0, md_busy=0, stall=0, all enables=1, independent of clk.
REQ-026 SHALL: reset asserted mid-operation abandons the count; the first edge after release evaluates in RUN.

Configuration
REQ-027 SHALL: with PIPE_CTRL_MDU_EN defined, the counter, the MD state and hz_md are implemented as above.
REQ-028 SHALL: without PIPE_CTRL_MDU_EN, md_busy is tied 0, hz_md is 0, E_md_start/E_md_op/D_is_md are ignored, and the FSM uses RUN/EXC only.

Structure
REQ-029 SHALL: package pipe_pkg holds the state encoding, MULT_CYCLES=5, DIV_CYCLES=10 and the Tuse/Tnew width constant (2).
REQ-030 SHALL: the counter is split into sub-module md_busy_counter (load, op, tick, busy); the hazard compare stays in pipe_ctrl.

Verification
REQ-031 SHALL: D_rs=5, D_Tuse_rs=0, E_A3=5, E_Tnew=1 -> stall=1, en_PC=0, en_FD=0, en_DE=1; E_Tnew=0 -> stall=0.
REQ-032 SHALL: D_rt=0 with E_A3=0, E_Tnew=2 -> stall=0 (register 0 never hazards).
REQ-033 SHALL: E_md_start=1, E_md_op=1, then D_is_md=1 held -> md_busy high 10 cycles, stall=1 throughout, stall=0 the cycle after count reaches 0.
REQ-034 SHALL: mult in flight (count=3) and Req pulse -> stall=0 and enables=1 that cycle, state=EXC for one cycle, then MD, md_busy low 3 cycles after start of count=3.
REQ-035 SHALL: E_md_start and Req together -> count stays 0, md_busy=0, state EXC then RUN.
REQ-036 SHALL: reset driven low mid-div (count=7) between clock edges -> md_busy=0 and state=RUN immediately; build without PIPE_CTRL_MDU_EN -> md_busy constant 0.
